and2_rr_sched: RTL and testbench
================================

// Module: and2_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one external and2 gate instance between
//  NREQ requesters. Each requester presents a 2-bit operand pair and a request;
//  the scheduler drives the winner's pair onto the gate's bb input, waits a
//  settle window, samples the gate's r output and returns it with a one-cycle
//  response strobe. It sits between the requester logic and the single shared and2.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  SETTLE_CYC  1   cycles gate_bb is held before gate_r is sampled (>=1)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  req        in   NREQ     request per requester; held high until served
//  opnd       in   2*NREQ   operand pairs; opnd[2i+1:2i] = {bb[1],bb[0]} of req i
//  gate_bb    out  2        to shared and2 bb input (registered)
//  gate_r     in   1        from shared and2 r output
//  grant      out  NREQ     one-hot, winner index during SETTLE and RESP
//  rsp_valid  out  NREQ     one-hot, 1-cycle pulse in RESP to the served requester
//  rsp_data   out  1        sampled gate_r; holds value until next RESP
//  busy       out  1        high in SETTLE and RESP
// BEHAVIOUR
//  Reset (rst_n=0, async, any state): state=IDLE, gate_bb=2'b00, grant=0,
//   rsp_valid=0, rsp_data=0, busy=0, rr pointer=0, settle counter=0.
//  FSM states IDLE, SETTLE, RESP:
//   IDLE: if any unmasked req, pick winner = first set bit searching upward
//    (mod NREQ) from pointer; load gate_bb<=opnd pair of winner, grant<=onehot,
//    counter<=SETTLE_CYC-1, -> SETTLE. No req: stay, outputs unchanged.
//   SETTLE: gate_bb and grant held constant; counter decrements; when counter==0
//    at the edge: rsp_data<=gate_r, rsp_valid<=grant, -> RESP.
//   RESP: one cycle; rsp_valid high; at edge rsp_valid<=0, grant<=0,
//    pointer<=(winner+1) mod NREQ, -> IDLE.
//  Latency: req sampled high in IDLE cycle 0 -> rsp_valid high in cycle
//   SETTLE_CYC+1. Service period per request = SETTLE_CYC+2 cycles.
//  Handshake: requester keeps req and its opnd pair stable until it sees
//   rsp_valid[i]; deasserts req the following cycle. The just-served index is
//   masked from arbitration in the first IDLE cycle after RESP.
//  Opnd changes during SETTLE are ignored (pair captured at grant).
//  Req withdrawn during SETTLE/RESP: service completes, rsp_valid still pulses.
//  Simultaneous reqs: strict rotation from pointer; no requester waits more than
//   NREQ-1 services while continuously requesting.
//  Pointer wraps NREQ-1 -> 0. gate_bb keeps last driven pair in IDLE.
//  grant, rsp_valid always one-hot or zero; never two bits set.
// TESTING (NREQ=4, SETTLE_CYC=1 unless stated)
//  1. Reset mid-SETTLE (rst_n low between edges) -> all outputs 0 immediately,
//     next service starts search at index 0.
//  2. req=4'b0100, opnd[5:4]=2'b11 -> gate_bb=11 and grant=0100 next cycle,
//     rsp_valid=0100 with rsp_data=1 two cycles after request.
//  3. req=4'b1111, pairs req0..3 = 00,01,10,11 -> served 0,1,2,3, rsp_data
//     0,0,0,1, rsp_valid pulses exactly 3 cycles apart.
//  4. req0 re-asserted right after each service, req3 raised during req0's
//     SETTLE -> next grant is req3, then req0; no back-to-back req0 grant.
//  5. req1 dropped during SETTLE -> rsp_valid[1] still pulses; pending req2
//     granted in the following IDLE cycle.
//  6. SETTLE_CYC=3, single req0 pair 11 -> rsp_valid[0] 4 cycles after request,
//     gate_bb stable for 3 cycles, rsp_data=1.

Source files
------------

// File: rtl/and2_rr_sched.sv
// Round-robin scheduler sharing one external and2 gate between NREQ requesters.
// The winner's operand pair is registered onto gate_bb, held for SETTLE_CYC cycles,
// then gate_r is sampled and returned with a one-cycle per-requester strobe.
module and2_rr_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] opnd,
  output logic [1:0]        gate_bb,
  input  logic              gate_r,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_data,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [CW-1:0]   cnt_q;
  logic            mask_q;   // last winner excluded for one IDLE cycle

  logic            found;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [1:0]      win_pair;
  logic [31:0]     cand;

  // Search upward from the pointer (wrapping) for the first unmasked request.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {{(32-IW){1'b0}}, ptr_q} + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req[cand[IW-1:0]] && !(mask_q && (cand[IW-1:0] == win_q))) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Decode the winner into a one-hot grant and its operand pair.
  always_comb begin
    win_oh   = '0;
    win_pair = 2'b00;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_oh[i] = 1'b1;
        win_pair  = opnd[2*i +: 2];
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= 1'b0;
      gate_bb   <= 2'b00;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          mask_q <= 1'b0;
          if (found) begin
            gate_bb <= win_pair;
            grant   <= win_oh;
            win_q   <= win_idx;
            cnt_q   <= CW'(SETTLE_CYC - 1);
            busy    <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            rsp_data  <= gate_r;
            rsp_valid <= grant;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          rsp_valid <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          ptr_q     <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          mask_q    <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_and2_rr_sched.sv
// Self-checking bench for and2_rr_sched: table of single-requester services plus
// hand-written sequences for rotation, masking, withdrawal and reset corners.
module tb_and2_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] opnd;
  logic [1:0] gate_bb;
  logic       gate_r;
  logic [3:0] grant;
  logic [3:0] rsp_valid;
  logic       rsp_data;
  logic       busy;

  logic [3:0] req3;
  logic [7:0] opnd3;
  logic [1:0] gate_bb3;
  logic       gate_r3;
  logic [3:0] grant3;
  logic [3:0] rsp_valid3;
  logic       rsp_data3;
  logic       busy3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         idx;
    logic [1:0] pair;
    logic       data;
  } vec_t;

  typedef struct {
    int   idx;
    logic data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  // Shared and2 gate models
  assign gate_r  = gate_bb[1] & gate_bb[0];
  assign gate_r3 = gate_bb3[1] & gate_bb3[0];

  and2_rr_sched #(.NREQ(4), .SETTLE_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .opnd      (opnd),
    .gate_bb   (gate_bb),
    .gate_r    (gate_r),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  and2_rr_sched #(.NREQ(4), .SETTLE_CYC(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req3),
    .opnd      (opnd3),
    .gate_bb   (gate_bb3),
    .gate_r    (gate_r3),
    .grant     (grant3),
    .rsp_valid (rsp_valid3),
    .rsp_data  (rsp_data3),
    .busy      (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int idx, input logic d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: every response is popped and compared; one-hot checks each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      if (rsp_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_idx", 32'(rsp_valid), 32'(1 << e.idx));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  // Wait (bounded) for a response; returns one cycle later, just after the RESP edge.
  task automatic wait_rsp(output logic [3:0] v, output int at);
    v  = 4'b0000;
    at = -1;
    for (int n = 0; n < 30 && v == 4'b0000; n++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0000) begin
        v  = rsp_valid;
        at = cyc;
      end
    end
    if (v == 4'b0000) chk("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic serve_one(input int idx, input logic [1:0] pair, input logic d);
    logic [3:0] v;
    int         t0;
    int         at;
    req               = 4'b0001 << idx;
    opnd[2*idx +: 2]  = pair;
    push(idx, d);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("svc_gate_bb", 32'(gate_bb), 32'(pair));
    chk("svc_grant", 32'(grant), 32'(1 << idx));
    chk("svc_busy", 32'(busy), 32'd1);
    wait_rsp(v, at);
    chk("svc_latency", 32'(at - t0), 32'd2);
    req = 4'b0000;
  endtask

  initial begin
    logic [3:0] v;
    int         a0, a1, a2, a3, t0;

    vecs[0] = '{idx: 2, pair: 2'b11, data: 1'b1};
    vecs[1] = '{idx: 0, pair: 2'b00, data: 1'b0};
    vecs[2] = '{idx: 1, pair: 2'b01, data: 1'b0};
    vecs[3] = '{idx: 3, pair: 2'b10, data: 1'b0};
    vecs[4] = '{idx: 1, pair: 2'b11, data: 1'b1};
    vecs[5] = '{idx: 0, pair: 2'b11, data: 1'b1};
    vecs[6] = '{idx: 3, pair: 2'b11, data: 1'b1};
    vecs[7] = '{idx: 2, pair: 2'b01, data: 1'b0};

    req   = 4'b0000;
    opnd  = 8'h00;
    req3  = 4'b0000;
    opnd3 = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gate_bb", 32'(gate_bb), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // All four request at once: strict rotation from index 0, pulses 3 cycles apart
    opnd = 8'b11_10_01_00;
    req  = 4'b1111;
    push(0, 1'b0); push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
    a0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(v, a1);
      chk("rot_order", 32'(v), 32'(1 << k));
      if (k > 0) chk("rot_period", 32'(a1 - a0), 32'd3);
      a0  = a1;
      req = req & ~v;
    end

    // Table of single-requester services
    for (int i = 0; i < 8; i++) begin
      serve_one(vecs[i].idx, vecs[i].pair, vecs[i].data);
    end

    // Reset mid-SETTLE, then search restarts at index 0
    serve_one(1, 2'b11, 1'b1);
    req  = 4'b0001;
    opnd = 8'b00_00_00_10;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gate_bb", 32'(gate_bb), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    opnd = 8'b11_00_00_10;
    req  = 4'b1001;
    push(0, 1'b0); push(3, 1'b1);
    wait_rsp(v, a0);
    chk("post_rst_first", 32'(v), 32'd1);
    req = req & ~v;
    wait_rsp(v, a0);
    chk("post_rst_second", 32'(v), 32'd8);
    req = req & ~v;

    // req0 held continuously, req3 arrives during req0's SETTLE
    opnd = 8'b00_00_00_11;
    req  = 4'b0001;
    push(0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    req[3] = 1'b1;
    push(3, 1'b0); push(0, 1'b1); push(0, 1'b1);
    wait_rsp(v, a0);
    chk("fair_first", 32'(v), 32'd1);
    wait_rsp(v, a1);
    chk("fair_req3", 32'(v), 32'd8);
    chk("fair_gap1", 32'(a1 - a0), 32'd3);
    req[3] = 1'b0;
    wait_rsp(v, a2);
    chk("fair_req0", 32'(v), 32'd1);
    chk("fair_gap2", 32'(a2 - a1), 32'd3);
    wait_rsp(v, a3);
    chk("mask_req0", 32'(v), 32'd1);
    chk("mask_gap", 32'(a3 - a2), 32'd4);
    req = 4'b0000;

    // req1 withdrawn during SETTLE still completes; pending req2 follows
    opnd = 8'b00_01_11_00;
    req  = 4'b0110;
    push(1, 1'b1); push(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("wd_grant1", 32'(grant), 32'd2);
    req[1] = 1'b0;
    wait_rsp(v, a0);
    chk("wd_rsp1", 32'(v), 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("wd_grant2", 32'(grant), 32'd4);
    chk("wd_gate_bb2", 32'(gate_bb), 32'd1);
    wait_rsp(v, a0);
    chk("wd_rsp2", 32'(v), 32'd4);
    req = 4'b0000;

    // Longer settle window on the second instance
    opnd3 = 8'b00_00_00_11;
    req3  = 4'b0001;
    t0    = cyc;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s3_gate_bb", 32'(gate_bb3), 32'd3);
      chk("s3_grant", 32'(grant3), 32'd1);
      chk("s3_no_rsp", 32'(rsp_valid3), 32'd0);
      chk("s3_busy", 32'(busy3), 32'd1);
    end
    @(negedge clk);
    chk("s3_rsp_valid", 32'(rsp_valid3), 32'd1);
    chk("s3_rsp_data", 32'(rsp_data3), 32'd1);
    chk("s3_latency", 32'(cyc - t0), 32'd4);
    @(posedge clk);
    #1 req3 = 4'b0000;
    @(negedge clk);
    chk("s3_rsp_cleared", 32'(rsp_valid3), 32'd0);
    chk("s3_data_held", 32'(rsp_data3), 32'd1);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
